// File: rtl/mips_load_store_unit_pkg.sv
// Shared MIPS load/store definitions: access sizes, LSU states, request record
// and the lane helpers used when a request is accepted.
package mips_load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } ls_state_t;

    typedef struct packed {
        logic                  write;
        ls_size_t              size;
        logic                  is_signed;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } ls_req_t;

    // Size code 11 is never legal; halves need an even address, words a 4-byte one.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            2'b10:   return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_WIDTH-1:0] byte_enables(input ls_size_t size,
                                                         input logic [1:0] off);
        case (size)
            LS_BYTE: return 4'b0001 << off;
            LS_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_lanes(input ls_size_t size,
                                                          input logic [DATA_WIDTH-1:0] w);
        case (size)
            LS_BYTE: return {(DATA_WIDTH/8){w[7:0]}};
            LS_HALF: return {(DATA_WIDTH/16){w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mips_load_formatter.sv
// Combinational load-data formatter: picks the byte/half lane addressed by the
// offset from the memory word and sign- or zero-extends it to a full word.
module mips_load_formatter
    import mips_load_store_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic [1:0]            i_size,
    input  logic                  i_signed,
    input  logic [1:0]            i_offset,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_mem_rdata[{i_offset, 3'b000} +: 8];
        w_half = i_mem_rdata[{i_offset[1], 4'b0000} +: 16];
        o_data = i_mem_rdata;
        case (ls_size_t'(i_size))
            LS_BYTE: o_data = {{(DATA_WIDTH-8){i_signed & w_byte[7]}}, w_byte};
            LS_HALF: o_data = {{(DATA_WIDTH-16){i_signed & w_half[15]}}, w_half};
            default: o_data = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS data-memory access stage: accepts one load/store, runs a req/ack bus cycle
// with byte enables and lane-replicated store data, and returns extended load data.
module mips_load_store_unit
    import mips_load_store_unit_pkg::*;
#(
    parameter int Timeout_Cycles = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ls_valid,
    input  logic                  i_ls_write,
    input  logic [1:0]            i_ls_size,
    input  logic                  i_ls_signed,
    input  logic [DATA_WIDTH-1:0] i_ls_addr,
    input  logic [DATA_WIDTH-1:0] i_ls_wdata,
    output logic                  o_ls_ready,
    output logic                  o_ls_done,
    output logic                  o_ls_error,
    output logic [DATA_WIDTH-1:0] o_ls_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [BE_WIDTH-1:0]   o_mem_be,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(Timeout_Cycles + 1);

    ls_state_t             r_state;
    ls_req_t               r_req;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;
    logic                  r_error;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [BE_WIDTH-1:0]   r_mem_be;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_legal;
    logic                  w_timeout;
    ls_size_t              w_size;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_size    = ls_size_t'(i_ls_size);
    assign w_legal   = is_legal(i_ls_size, i_ls_addr[1:0]);
    assign w_timeout = (r_cnt == CNT_W'(Timeout_Cycles - 1));

    mips_load_formatter u_formatter (
        .i_mem_rdata (i_mem_rdata),
        .i_size      (r_req.size),
        .i_signed    (r_req.is_signed),
        .i_offset    (r_req.addr[1:0]),
        .o_data      (w_load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    if (i_ls_valid) begin
                        r_req.write     <= i_ls_write;
                        r_req.size      <= w_size;
                        r_req.is_signed <= i_ls_signed;
                        r_req.addr      <= i_ls_addr;
                        r_req.wdata     <= store_lanes(w_size, i_ls_wdata);
                        r_cnt           <= '0;
                        r_rdata         <= '0;
                        if (w_legal) begin
                            r_mem_req <= 1'b1;
                            r_mem_we  <= i_ls_write;
                            r_mem_be  <= byte_enables(w_size, i_ls_addr[1:0]);
                            r_state   <= REQ;
                        end else begin
                            // Rejected without touching the bus.
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The ack is checked first so an ack on the last allowed cycle still succeeds.
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_rdata   <= r_req.write ? '0 : w_load_data;
                        r_done    <= 1'b1;
                        r_error   <= 1'b0;
                        r_state   <= RESP;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_rdata   <= '0;
                        r_done    <= 1'b1;
                        r_error   <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done    <= 1'b0;
                    r_error   <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_ls_ready  = (r_state == IDLE);
    assign o_ls_done   = r_done;
    assign o_ls_error  = r_error;
    assign o_ls_rdata  = r_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = {r_req.addr[DATA_WIDTH-1:2], 2'b00};
    assign o_mem_wdata = r_req.wdata;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for the load/store unit: each step drives one request and checks
// bus signals, completion timing and returned data against hand-computed values.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_write, ls_signed;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_done, ls_error;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_load_store_unit #(.Timeout_Cycles(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ls_valid  (ls_valid),
        .i_ls_write  (ls_write),
        .i_ls_size   (ls_size),
        .i_ls_signed (ls_signed),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .o_ls_ready  (ls_ready),
        .o_ls_done   (ls_done),
        .o_ls_error  (ls_error),
        .o_ls_rdata  (ls_rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request from a negedge, wait for acceptance, return at the negedge of cycle N+1.
    task automatic issue(input string tag, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        int guard;
        ls_valid  = 1'b1;
        ls_write  = wr;
        ls_size   = sz;
        ls_signed = sg;
        ls_addr   = a;
        ls_wdata  = wd;
        guard     = 0;
        while (!ls_ready && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".ready_before_accept"}, ls_ready, 1'b1);
        @(negedge clk);
        ls_valid = 1'b0;
    endtask

    task automatic do_access(input string tag, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rdata);
        issue(tag, wr, sz, sg, a, wd);
        chk({tag, ".mem_req"}, mem_req, 1'b1);
        chk({tag, ".mem_be"}, mem_be, exp_be);
        chk({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".mem_we"}, mem_we, wr);
        if (wr) chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        for (int k = 0; k < waits; k++) begin
            chk({tag, ".done_while_waiting"}, ls_done, 1'b0);
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, ".done"}, ls_done, 1'b1);
        chk({tag, ".error"}, ls_error, 1'b0);
        chk({tag, ".rdata"}, ls_rdata, exp_rdata);
        chk({tag, ".req_dropped"}, mem_req, 1'b0);
        chk({tag, ".ready_in_resp"}, ls_ready, 1'b0);
    endtask

    task automatic do_reject(input string tag, input logic [1:0] sz, input logic [31:0] a);
        issue(tag, 1'b0, sz, 1'b0, a, 32'h0);
        chk({tag, ".done"}, ls_done, 1'b1);
        chk({tag, ".error"}, ls_error, 1'b1);
        chk({tag, ".mem_req"}, mem_req, 1'b0);
        chk({tag, ".rdata"}, ls_rdata, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        ls_valid = 1'b0; ls_write = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        @(negedge clk);
        chk("reset.ready", ls_ready, 1'b1);
        chk("reset.done", ls_done, 1'b0);
        chk("reset.error", ls_error, 1'b0);
        chk("reset.mem_req", mem_req, 1'b0);
        chk("reset.mem_we", mem_we, 1'b0);
        chk("reset.mem_be", mem_be, 4'b0000);
        chk("reset.mem_addr", mem_addr, 32'h0);
        chk("reset.mem_wdata", mem_wdata, 32'h0);
        chk("reset.rdata", ls_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_access("sw", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,
                  4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_access("lb_0x13", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 3, 32'h80AB_CDEF,
                  4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("lhu_0x22", 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 0, 32'h9ABC_1234,
                  4'b1100, 32'h0, 32'h0000_9ABC);
        do_access("lb_0x11", 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0, 1, 32'h80AB_CDEF,
                  4'b0010, 32'h0, 32'hFFFF_FFCD);
        do_access("lbu_0x11", 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 0, 32'h80AB_CDEF,
                  4'b0010, 32'h0, 32'h0000_00CD);
        do_access("lh_0x22", 1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 0, 32'h8001_7FFF,
                  4'b1100, 32'h0, 32'hFFFF_8001);
        do_access("lh_0x20", 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0, 0, 32'h8001_7FFF,
                  4'b0011, 32'h0, 32'h0000_7FFF);
        do_access("sh_0x2", 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 0, 32'h0,
                  4'b1100, 32'hABCD_ABCD, 32'h0);
        do_access("ack_at_limit", 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 15, 32'h0123_4567,
                  4'b1111, 32'h0, 32'h0123_4567);

        do_reject("misaligned_word", 2'b10, 32'h0000_0006);
        do_reject("misaligned_half", 2'b01, 32'h0000_0005);
        do_reject("illegal_size", 2'b11, 32'h0000_0008);

        // No ack for the whole timeout window, then a stray late ack.
        do_access("lw_before_timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 0,
                  32'h5555_AAAA, 4'b1111, 32'h0, 32'h5555_AAAA);
        issue("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        for (int k = 0; k < 16; k++) begin
            chk("timeout.req_held", mem_req, 1'b1);
            chk("timeout.no_early_done", ls_done, 1'b0);
            @(negedge clk);
        end
        chk("timeout.done", ls_done, 1'b1);
        chk("timeout.error", ls_error, 1'b1);
        chk("timeout.req_dropped", mem_req, 1'b0);
        chk("timeout.rdata", ls_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack.ready", ls_ready, 1'b1);
        chk("late_ack.done", ls_done, 1'b0);
        chk("late_ack.mem_req", mem_req, 1'b0);
        chk("late_ack.rdata", ls_rdata, 32'h0);

        // Reset asserted in the second wait cycle of a load.
        issue("reset_mid", 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        chk("reset_mid.req_before", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid.req_async_drop", mem_req, 1'b0);
        chk("reset_mid.ready", ls_ready, 1'b1);
        chk("reset_mid.done", ls_done, 1'b0);
        @(negedge clk);
        chk("reset_mid.done_held", ls_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_mid.done_after", ls_done, 1'b0);
        chk("reset_mid.ready_after", ls_ready, 1'b1);

        do_access("sb_0x1", 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_005A, 0, 32'h0,
                  4'b0010, 32'h5A5A_5A5A, 32'h0);

        @(negedge clk);
        chk("final.ready", ls_ready, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
